// File: rtl/cnn_mem_pkg.sv
// Shared types and defaults for the dual-port CNN parameter/image scratch RAM.
package cnn_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 256;

    // Address width that stays legal for a single-word array.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cnn_mem_dp_if.sv
// Host memory-mapped slave bus plus engine read port of cnn_mem_dp.
interface cnn_mem_dp_if
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] val_out;
    logic              val_valid;
    logic              eng_rd;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;
    logic              eng_valid;

    modport slave (
        input  chipselect, address, write, writedata, byteenable, read,
        input  eng_rd, eng_addr,
        output waitrequest, val_out, val_valid, eng_data, eng_valid
    );

    modport master (
        output chipselect, address, write, writedata, byteenable, read,
        output eng_rd, eng_addr,
        input  waitrequest, val_out, val_valid, eng_data, eng_valid
    );

endinterface

// File: rtl/cnn_mem_bank.sv
// Storage array: one byte-masked write port, two registered read ports,
// read-before-write, out-of-range writes dropped and reads returning zero.
module cnn_mem_bank
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [addr_w(DEPTH)-1:0]      waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W/8-1:0]           wbe,
    input  logic                          rd_a,
    input  logic [addr_w(DEPTH)-1:0]      raddr_a,
    output logic [DATA_W-1:0]             rdata_a,
    input  logic                          rd_b,
    input  logic [addr_w(DEPTH)-1:0]      raddr_b,
    output logic [DATA_W-1:0]             rdata_b
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int BE_W   = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    always_ff @(posedge clk) begin
        if (we && in_range(waddr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read stage: both ports sample the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (rd_a) rdata_a <= in_range(raddr_a) ? mem[raddr_a] : '0;
            if (rd_b) rdata_b <= in_range(raddr_b) ? mem[raddr_b] : '0;
        end
    end

endmodule

// File: rtl/cnn_mem_dp.sv
// Dual-port CNN scratch RAM: FSM, clear sweep, request qualification, valid strobes.
// Optional post-reset zeroing sweep is built when CNN_MEM_CLEAR_EN is defined.
module cnn_mem_dp
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    cnn_mem_dp_if.slave  bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    state_t            state_q, state_d;
    logic              run;
    logic              clear_wr;
    logic [ADDR_W-1:0] clr_addr;

`ifdef CNN_MEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        run      = 1'b0;
        clear_wr = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_wr = 1'b1;
                if (clr_ptr == LAST) state_d = RUN;
            end
            RUN: run = 1'b1;
        endcase
    end

    assign clr_addr        = clr_ptr;
    assign bus.waitrequest = clear_wr;
`else
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        run      = (state_q == RUN);
        clear_wr = 1'b0;
    end

    assign clr_addr        = '0;
    assign bus.waitrequest = 1'b0;
`endif

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   wbe;
    logic              host_rd, eng_rd;
    logic              host_vld_p1, eng_vld_p1;

    // The sweep owns the write port; a host read paired with a write is dropped.
    assign we      = clear_wr | (run & bus.chipselect & bus.write);
    assign waddr   = clear_wr ? clr_addr : bus.address;
    assign wdata   = clear_wr ? '0 : bus.writedata;
    assign wbe     = clear_wr ? '1 : bus.byteenable;
    assign host_rd = run & bus.chipselect & bus.read & ~bus.write;
    assign eng_rd  = run & bus.eng_rd;

    cnn_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .wbe     (wbe),
        .rd_a    (host_rd),
        .raddr_a (bus.address),
        .rdata_a (bus.val_out),
        .rd_b    (eng_rd),
        .raddr_b (bus.eng_addr),
        .rdata_b (bus.eng_data)
    );

    // Stage 1: valid strobes aligned with the registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_vld_p1 <= 1'b0;
            eng_vld_p1  <= 1'b0;
        end else begin
            host_vld_p1 <= host_rd;
            eng_vld_p1  <= eng_rd;
        end
    end

    assign bus.val_valid = host_vld_p1;
    assign bus.eng_valid = eng_vld_p1;

endmodule

// File: tb/tb_cnn_mem_dp.sv
// Self-checking bench for cnn_mem_dp: directed vector table, sweep/reset sequences,
// out-of-range checks on a DEPTH=200 instance and a randomized run against a word-array model.
module tb_cnn_mem_dp;
    import cnn_mem_pkg::*;

    localparam int D0 = 256;
    localparam int D1 = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cnn_mem_dp_if #(.DATA_W(16), .DEPTH(D0)) bus0 ();
    cnn_mem_dp_if #(.DATA_W(16), .DEPTH(D1)) bus1 ();

    cnn_mem_dp #(.DATA_W(16), .DEPTH(D0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    cnn_mem_dp #(.DATA_W(16), .DEPTH(D1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int errors = 0;
    int checks = 0;

    logic [15:0] m0 [D0];
    logic [15:0] m1 [D1];

    typedef struct {
        logic        cs, wr, rd;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        erd;
        logic [7:0]  eaddr;
        logic        vv;
        logic [15:0] vo;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic cs, wr, rd, input logic [7:0] addr,
                                input logic [15:0] wd, input logic [1:0] be,
                                input logic erd, input logic [7:0] eaddr,
                                input logic vv, input logic [15:0] vo,
                                input logic ev, input logic [15:0] ed);
        vec_t v;
        v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.be = be;
        v.erd = erd; v.eaddr = eaddr; v.vv = vv; v.vo = vo; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.chipselect = 0; bus0.write = 0; bus0.read = 0; bus0.address = '0;
        bus0.writedata = '0; bus0.byteenable = '0; bus0.eng_rd = 0; bus0.eng_addr = '0;
    endtask

    task automatic idle1();
        bus1.chipselect = 0; bus1.write = 0; bus1.read = 0; bus1.address = '0;
        bus1.writedata = '0; bus1.byteenable = '0; bus1.eng_rd = 0; bus1.eng_addr = '0;
    endtask

    task automatic drive0(input logic cs, wr, rd, input logic [7:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input logic erd, input logic [7:0] ea);
        bus0.chipselect = cs; bus0.write = wr; bus0.read = rd; bus0.address = a;
        bus0.writedata = wd; bus0.byteenable = be; bus0.eng_rd = erd; bus0.eng_addr = ea;
    endtask

    task automatic drive1(input logic cs, wr, rd, input logic [7:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input logic erd, input logic [7:0] ea);
        bus1.chipselect = cs; bus1.write = wr; bus1.read = rd; bus1.address = a;
        bus1.writedata = wd; bus1.byteenable = be; bus1.eng_rd = erd; bus1.eng_addr = ea;
    endtask

    initial begin
        logic [15:0] e0_vo, e0_ed, e1_vo, e1_ed;
        logic        exp_wait;
        int          n;
        logic        leak;

        for (int a = 0; a < D0; a++) m0[a] = 16'h0000;
        for (int a = 0; a < D1; a++) m1[a] = 16'h0000;

`ifdef CNN_MEM_CLEAR_EN
        exp_wait = 1'b1;
`else
        exp_wait = 1'b0;
`endif

        // Reset held for three cycles.
        idle0(); idle1();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_val_out", bus0.val_out, 16'h0);
        chk("rst_val_valid", bus0.val_valid, 1'b0);
        chk("rst_eng_data", bus0.eng_data, 16'h0);
        chk("rst_eng_valid", bus0.eng_valid, 1'b0);
        chk("rst_waitrequest", bus0.waitrequest, exp_wait);
        chk("rst_val_valid_d200", bus1.val_valid, 1'b0);
        reset = 1'b0;

`ifdef CNN_MEM_CLEAR_EN
        // Partial sweep, then reset pulsed at sweep cycle 100.
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        leak = 1'b0;
        while (bus0.waitrequest === 1'b1 && n < 1000) begin
            if (n == 20)      drive0(1, 1, 0, 8'd3, 16'h5555, 2'b11, 1, 8'd3);
            else if (n == 21) drive0(1, 0, 1, 8'd3, 16'h0, 2'b00, 1, 8'd3);
            else              idle0();
            n++;
            tick();
            if (bus0.val_valid !== 1'b0 || bus0.eng_valid !== 1'b0) leak = 1'b1;
        end
        idle0();
        chk("sweep_wait_cycles", n, 256);
        chk("sweep_no_valid", leak, 1'b0);
        chk("sweep_d200_done", bus1.waitrequest, 1'b0);
        foreach (tbl[i]) begin end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ra;
            ra = (k == 0) ? 8'd0 : (k == 1) ? 8'd128 : (k == 2) ? 8'd255 : 8'd3;
            drive0(1, 0, 1, ra, 16'h0, 2'b00, 0, 8'd0);
            tick();
            idle0();
            chk($sformatf("swept_rd%0d_valid", ra), bus0.val_valid, 1'b1);
            chk($sformatf("swept_rd%0d_data", ra), bus0.val_out, 16'h0);
            tick();
            chk($sformatf("swept_rd%0d_strobe_end", ra), bus0.val_valid, 1'b0);
        end
`else
        chk("run_waitrequest", bus0.waitrequest, 1'b0);
        for (int a = 0; a < D0; a++) begin
            drive0(1, 1, 0, 8'(a), 16'h0, 2'b11, 0, 8'd0);
            drive1(a < D1, 1, 0, 8'(a), 16'h0, 2'b11, 0, 8'd0);
            tick();
        end
        idle0(); idle1();
        tick();
`endif

        // Directed vectors on the 256-word instance, starting from all-zero memory.
        //              cs wr rd addr   wdata     be    erd ea    vv vo        ev ed
        tbl[0]  = mk(1, 1, 0, 8'd5, 16'hBEEF, 2'b11, 0, 8'd0, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 0, 8'd5, 16'h12FF, 2'b10, 0, 8'd0, 0, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(1, 0, 1, 8'd5, 16'h0000, 2'b00, 0, 8'd0, 1, 16'h12EF, 0, 16'h0000);
        tbl[3]  = mk(1, 1, 0, 8'd5, 16'hAAAA, 2'b11, 1, 8'd5, 0, 16'h12EF, 1, 16'h12EF);
        tbl[4]  = mk(0, 0, 0, 8'd0, 16'h0000, 2'b00, 1, 8'd5, 0, 16'h12EF, 1, 16'hAAAA);
        tbl[5]  = mk(1, 1, 1, 8'd7, 16'h0042, 2'b11, 0, 8'd0, 0, 16'h12EF, 0, 16'hAAAA);
        tbl[6]  = mk(0, 0, 0, 8'd0, 16'h0000, 2'b00, 0, 8'd0, 0, 16'h12EF, 0, 16'hAAAA);
        tbl[7]  = mk(1, 0, 1, 8'd7, 16'h0000, 2'b00, 0, 8'd0, 1, 16'h0042, 0, 16'hAAAA);
        tbl[8]  = mk(0, 1, 1, 8'd7, 16'hFFFF, 2'b11, 0, 8'd0, 0, 16'h0042, 0, 16'hAAAA);
        tbl[9]  = mk(1, 0, 1, 8'd7, 16'h0000, 2'b00, 0, 8'd0, 1, 16'h0042, 0, 16'hAAAA);
        tbl[10] = mk(1, 1, 0, 8'd7, 16'h1111, 2'b00, 0, 8'd0, 0, 16'h0042, 0, 16'hAAAA);
        tbl[11] = mk(1, 0, 1, 8'd7, 16'h0000, 2'b00, 1, 8'd5, 1, 16'h0042, 1, 16'hAAAA);
        tbl[12] = mk(1, 0, 1, 8'd5, 16'h0000, 2'b00, 0, 8'd0, 1, 16'hAAAA, 0, 16'hAAAA);

        for (int i = 0; i < 13; i++) begin
            drive0(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].be,
                   tbl[i].erd, tbl[i].eaddr);
            tick();
            chk($sformatf("vec%0d_val_valid", i), bus0.val_valid, tbl[i].vv);
            chk($sformatf("vec%0d_val_out", i), bus0.val_out, tbl[i].vo);
            chk($sformatf("vec%0d_eng_valid", i), bus0.eng_valid, tbl[i].ev);
            chk($sformatf("vec%0d_eng_data", i), bus0.eng_data, tbl[i].ed);
        end
        idle0();
        m0[5] = 16'hAAAA;
        m0[7] = 16'h0042;
        e0_vo = 16'hAAAA;
        e0_ed = 16'hAAAA;

        // Out-of-range accesses on the 200-word instance.
        drive1(1, 1, 0, 8'd210, 16'hFFFF, 2'b11, 0, 8'd0);
        tick();
        drive1(1, 1, 0, 8'd199, 16'h1234, 2'b11, 0, 8'd0);
        tick();
        m1[199] = 16'h1234;
        drive1(1, 0, 1, 8'd210, 16'h0, 2'b00, 1, 8'd210);
        tick();
        chk("oor_val_valid", bus1.val_valid, 1'b1);
        chk("oor_val_out", bus1.val_out, 16'h0);
        chk("oor_eng_valid", bus1.eng_valid, 1'b1);
        chk("oor_eng_data", bus1.eng_data, 16'h0);
        for (int a = 0; a < D1; a++) begin
            drive1(1, 0, 1, 8'(a), 16'h0, 2'b00, 0, 8'd0);
            tick();
            if (bus1.val_valid !== 1'b1 || bus1.val_out !== m1[a])
                chk($sformatf("d200_word%0d", a), {15'h0, bus1.val_valid, bus1.val_out},
                    {16'h1, m1[a]});
            else
                checks++;
        end
        idle1();
        e1_vo = m1[D1-1];
        e1_ed = 16'h0;

        // Randomized traffic on both instances against the word-array models.
        for (int c = 0; c < 400; c++) begin
            logic        cs0, wr0, rd0, er0, cs1, wr1, rd1, er1;
            logic [7:0]  a0, ea0, a1, ea1;
            logic [15:0] wd0, wd1;
            logic [1:0]  be0, be1;
            logic        xv0, xe0, xv1, xe1;

            cs0 = ($urandom % 4) != 0; wr0 = ($urandom % 3) == 0; rd0 = $urandom % 2;
            er0 = $urandom % 2; a0 = 8'($urandom); ea0 = 8'($urandom);
            wd0 = 16'($urandom); be0 = 2'($urandom);
            cs1 = ($urandom % 4) != 0; wr1 = ($urandom % 3) == 0; rd1 = $urandom % 2;
            er1 = $urandom % 2; a1 = 8'($urandom); ea1 = 8'($urandom);
            wd1 = 16'($urandom); be1 = 2'($urandom);

            xv0 = cs0 && rd0 && !wr0;
            if (xv0) e0_vo = m0[a0];
            xe0 = er0;
            if (xe0) e0_ed = m0[ea0];
            if (cs0 && wr0)
                for (int b = 0; b < 2; b++) if (be0[b]) m0[a0][8*b +: 8] = wd0[8*b +: 8];

            xv1 = cs1 && rd1 && !wr1;
            if (xv1) e1_vo = (a1 < D1) ? m1[a1] : 16'h0;
            xe1 = er1;
            if (xe1) e1_ed = (ea1 < D1) ? m1[ea1] : 16'h0;
            if (cs1 && wr1 && a1 < D1)
                for (int b = 0; b < 2; b++) if (be1[b]) m1[a1][8*b +: 8] = wd1[8*b +: 8];

            drive0(cs0, wr0, rd0, a0, wd0, be0, er0, ea0);
            drive1(cs1, wr1, rd1, a1, wd1, be1, er1, ea1);
            tick();
            chk($sformatf("rnd%0d_d256_val_valid", c), bus0.val_valid, xv0);
            chk($sformatf("rnd%0d_d256_val_out", c), bus0.val_out, e0_vo);
            chk($sformatf("rnd%0d_d256_eng_valid", c), bus0.eng_valid, xe0);
            chk($sformatf("rnd%0d_d256_eng_data", c), bus0.eng_data, e0_ed);
            chk($sformatf("rnd%0d_d200_val_valid", c), bus1.val_valid, xv1);
            chk($sformatf("rnd%0d_d200_val_out", c), bus1.val_out, e1_vo);
            chk($sformatf("rnd%0d_d200_eng_valid", c), bus1.eng_valid, xe1);
            chk($sformatf("rnd%0d_d200_eng_data", c), bus1.eng_data, e1_ed);
        end
        idle0(); idle1();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_mem_dp.md
Name: cnn_mem_dp

Overview:
- Parametrised successor to the single-port CNN parameter/image scratch RAM.
- Host side: chipselect-qualified memory-mapped slave with byte enables, waitrequest and a registered read with valid strobe.
- Engine side: independent read-only port for the CNN datapath, so weights and pixels stream out while the host loads the next layer.
- Post-reset zeroing is a counter-driven sweep rather than a combinational loop over the array.

Parameters:
- DATA_W, 16, word width; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.
- BE_W, DATA_W/8, byte-enable width; derived localparam.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  host access qualifier.
- address  in  ADDR_W  host word address.
- write  in  1  host write strobe, qualified by chipselect.
- writedata  in  DATA_W  host write data.
- byteenable  in  BE_W  per-byte write mask; bit i covers writedata[8i+7:8i].
- read  in  1  host read strobe, qualified by chipselect.
- waitrequest  out  1  high while the block cannot accept host accesses.
- val_out  out  DATA_W  host read data, registered.
- val_valid  out  1  one-cycle strobe: val_out holds the data for an accepted read.
- eng_rd  in  1  engine read request.
- eng_addr  in  ADDR_W  engine word address.
- eng_data  out  DATA_W  engine read data, registered.
- eng_valid  out  1  one-cycle strobe for eng_data.

Behaviour:
- Reset values: val_out=0, val_valid=0, eng_data=0, eng_valid=0, waitrequest=1 (CLEAR_EN) / 0 (without), FSM=CLEAR (CLEAR_EN) / RUN (without), clr_ptr=0.
- FSM CLEAR:
  - Writes 0 to ram[clr_ptr] each cycle and increments clr_ptr.
  - At clr_ptr==DEPTH-1, writes the last word and goes to RUN the next cycle.
  - Takes exactly DEPTH cycles from the first cycle after reset deasserts.
  - waitrequest=1 throughout; host and engine requests are ignored (not queued); val_valid and eng_valid stay 0.
- FSM RUN:
  - waitrequest=0.
  - There is no path back to CLEAR except reset.
- Reset asserted mid-CLEAR or mid-RUN: clr_ptr returns to 0 and the sweep restarts from word 0. The RAM array itself is not reset; only the sweep clears it.
- Host write (RUN, chipselect&&write):
  - For every byte i with byteenable[i]=1, ram[address] byte i <= writedata byte i. Other bytes are kept.
  - byteenable=0 is a legal no-op.
- Host read (RUN, chipselect&&read&&!write):
  - Next cycle: val_out=ram[address], val_valid=1.
  - Latency is exactly 1 cycle and back-to-back reads are accepted every cycle.
  - val_out holds its value between reads; val_valid is 0 on any cycle with no accepted read.
- Simultaneous host write and read on the same cycle: the write is performed, the read is dropped, no val_valid.
- Engine read (RUN, eng_rd): next cycle eng_data=ram[eng_addr], eng_valid=1. Latency is 1 cycle and the port is fully pipelined.
- Host write and engine read to the same address on the same cycle: eng_data returns the OLD word (read-before-write). The new word is visible from the following cycle.
- Host read and write on the same cycle are resolved as above; host read and engine read are independent, with no arbitration and no stall.
- Out-of-range address (address>=DEPTH, only possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return 0 with the valid strobe still asserted.
- chipselect=0: write and read are ignored regardless of their level.

Optional Feature:
- Macro: CNN_MEM_CLEAR_EN.
- Defined: the CLEAR sweep is built as described above, and the RAM reads all-zero after the sweep.
- Undefined: no sweep and no clr_ptr. The FSM resets straight to RUN, waitrequest is tied to 0, accesses are accepted on the first cycle after reset, and RAM contents after power-up are undefined.

Decomposition:
- Package cnn_mem_pkg: FSM state enum (CLEAR, RUN) and default DATA_W/DEPTH constants.
- Sub-module cnn_mem_bank: the array, with one byte-masked write port and two registered read ports, read-before-write semantics and out-of-range masking.
- The top level holds the FSM, clear counter, request qualification and valid strobes.

Test Plan:
- Reset held 3 cycles, then released with CLEAR_EN -> waitrequest=1 for exactly 256 cycles, then 0; reads of addresses 0, 128 and 255 return 0x0000 with val_valid one cycle later.
- Write 0xBEEF to addr 5 with byteenable=2'b11, then write 0x12xx with byteenable=2'b10 -> a read of addr 5 returns 0x12EF.
- Engine reads addr 5 on the same cycle a host write of 0xAAAA lands there -> eng_data=0x12EF; an engine read the next cycle -> 0xAAAA.
- Host read and write asserted together at addr 7, data 0x0042 -> no val_valid that cycle or the next; a later read returns 0x0042.
- Reset pulsed at sweep cycle 100 -> waitrequest stays 1 for a further full 256 cycles; an access attempted during the sweep produces no write and no valid.
- DEPTH=200: write 0xFFFF to addr 210, then read addr 210 -> val_out=0, val_valid=1; addresses 0-199 are unaffected.
